// File: rtl/ascon_perm_sequencer.sv
// Iterative Ascon permutation controller applying UNROLL rounds (pc, ps, pl) per clock.
// Define ASCON_PERM_ABORT_EN to add a synchronous abort input.

module ascon_perm_round (
    input  logic [319:0] din,
    input  logic [3:0]   rnd,
    output logic [7:0]   rc,
    output logic [319:0] dout
);
    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    assign rc = {4'hF - rnd, rnd};

    always_comb begin
        x0 = din[319:256];
        x1 = din[255:192];
        x2 = din[191:128] ^ {56'h0, rc};
        x3 = din[127:64];
        x4 = din[63:0];
        // substitution layer, bit-sliced 5-bit S-box across the 64 columns
        a0 = x0 ^ x4;
        a1 = x1;
        a2 = x2 ^ x1;
        a3 = x3;
        a4 = x4 ^ x3;
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);
        s0 = b0 ^ b4;
        s1 = b1 ^ b0;
        s2 = ~b2;
        s3 = b3 ^ b2;
        s4 = b4;
        // linear diffusion layer
        dout = {s0 ^ ror(s0, 19) ^ ror(s0, 28),
                s1 ^ ror(s1, 61) ^ ror(s1, 39),
                s2 ^ ror(s2, 1)  ^ ror(s2, 6),
                s3 ^ ror(s3, 10) ^ ror(s3, 17),
                s4 ^ ror(s4, 7)  ^ ror(s4, 41)};
    end
endmodule

module ascon_perm_sequencer #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic         rounds_sel,
    input  logic [319:0] state_in,
    output logic         done_valid,
    input  logic         done_ready,
`ifdef ASCON_PERM_ABORT_EN
    input  logic         abort,
`endif
    output logic [319:0] state_out,
    output logic         busy
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("ascon_perm_sequencer: UNROLL must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

    st_t                     st, st_nxt;
    logic [319:0]            state_reg;
    logic [3:0]              r, r_step;
    logic                    load, step, clr;
    logic [UNROLL:0][319:0]  chain;

    assign chain[0]  = state_reg;
    assign r_step    = r + 4'(UNROLL);
    assign state_out = state_reg;

    for (genvar i = 0; i < UNROLL; i++) begin : g_lane
        logic [7:0] rc;
        ascon_perm_round u_round (
            .din  (chain[i]),
            .rnd  (r + 4'(i)),
            .rc   (rc),
            .dout (chain[i+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            state_reg <= '0;
            r         <= '0;
        end else begin
            st <= st_nxt;
            if (clr) begin
                state_reg <= '0;
                r         <= '0;
            end else if (load) begin
                state_reg <= state_in;
                r         <= rounds_sel ? 4'd4 : 4'd0;
            end else if (step) begin
                state_reg <= chain[UNROLL];
                r         <= r_step;
            end
        end
    end

    always_comb begin
        st_nxt      = st;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        clr         = 1'b0;
        case (st)
            IDLE: begin
                start_ready = !rst;
                if (start_valid && !rst) begin
                    load   = 1'b1;
                    st_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (r_step == 4'd12) st_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done_valid = 1'b1;
                if (done_ready) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
`ifdef ASCON_PERM_ABORT_EN
        // abort wins over everything else once an operation is in flight
        if (abort && st != IDLE) begin
            load   = 1'b0;
            step   = 1'b0;
            clr    = 1'b1;
            st_nxt = IDLE;
        end
`endif
    end
endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Self-checking bench for ascon_perm_sequencer: vector table, scoreboard queue, corner sequences.

module tb_ascon_perm_sequencer;
    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid, rounds_sel, done_ready, abort;
    logic [319:0] state_in;
    logic         start_ready, done_valid, busy;
    logic [319:0] state_out;
    logic         start_valid4, done_ready4, abort4;
    logic         start_ready4, done_valid4, busy4;
    logic [319:0] state_out4;

    int n_chk = 0;
    int n_fail = 0;
    logic [319:0] exp_q[$];
    logic [319:0] last_exp;

    always #5 clk = ~clk;

    ascon_perm_sequencer #(.UNROLL(1)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .rounds_sel(rounds_sel), .state_in(state_in), .done_valid(done_valid),
        .done_ready(done_ready),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort),
`endif
        .state_out(state_out), .busy(busy)
    );

    ascon_perm_sequencer #(.UNROLL(4)) dut4 (
        .clk(clk), .rst(rst), .start_valid(start_valid4), .start_ready(start_ready4),
        .rounds_sel(rounds_sel), .state_in(state_in), .done_valid(done_valid4),
        .done_ready(done_ready4),
`ifdef ASCON_PERM_ABORT_EN
        .abort(abort4),
`endif
        .state_out(state_out4), .busy(busy4)
    );

    // ---------------- reference model (table S-box, per-bit rotation) ----------------
    function automatic logic [4:0] sbox(input logic [4:0] i);
        case (i)
            5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
            5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
            5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
            5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
            5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
            5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
            5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
            5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [63:0] o;
        for (int b = 0; b < 64; b++) o[b] = v[(b + n) % 64];
        return o;
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
        logic [63:0] x[5];
        logic [63:0] y[5];
        logic [4:0]  c, o;
        int ra[5];
        int rb[5];
        ra = '{19, 61, 1, 10, 7};
        rb = '{28, 39, 6, 17, 41};
        for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
        x[2][7:0] = x[2][7:0] ^ {4'(15 - r), 4'(r)};
        for (int b = 0; b < 64; b++) begin
            c = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            o = sbox(c);
            for (int j = 0; j < 5; j++) y[j][b] = o[4 - j];
        end
        for (int j = 0; j < 5; j++) x[j] = y[j] ^ rotr(y[j], ra[j]) ^ rotr(y[j], rb[j]);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input logic sel);
        logic [319:0] t;
        t = s;
        for (int r = (sel ? 4 : 0); r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [319:0] act, input logic [319:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_exp(input string nm, output logic [319:0] e);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    // Called at the negedge right after the accepting edge; returns in DONE without handshaking.
    task automatic wait_for_done(input int lat, input logic [3:0] r0, input string tag);
        int cyc;
        logic [319:0] e;
        cyc = 0;
        check({tag, "_rc_first"}, {312'h0, dut.g_lane[0].rc}, {312'h0, 4'hF - r0, r0});
        while (!done_valid && cyc < 64) begin
            if (cyc == lat - 1) check({tag, "_rc_last"}, {312'h0, dut.g_lane[0].rc}, 320'h4b);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 320'(cyc), 320'(lat));
        pop_exp(tag, e);
        last_exp = e;
        check({tag, "_data"}, state_out, e);
    endtask

    task automatic handshake(input string tag);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check({tag, "_dv_drop"}, {319'h0, done_valid}, 320'h0);
        check({tag, "_idle"}, {318'h0, busy, start_ready}, 320'h1);
    endtask

    task automatic accept(input logic [319:0] s, input logic sel, input string tag);
        @(negedge clk);
        check({tag, "_start_ready"}, {319'h0, start_ready}, 320'h1);
        start_valid = 1'b1;
        state_in    = s;
        rounds_sel  = sel;
        exp_q.push_back(model_perm(s, sel));
        @(negedge clk);
        start_valid = 1'b0;
        state_in    = rand320();
        rounds_sel  = $urandom_range(0, 1);
    endtask

    task automatic run_one(input logic [319:0] s, input logic sel, input string tag);
        accept(s, sel, tag);
        wait_for_done(sel ? 8 : 12, sel ? 4'd4 : 4'd0, tag);
        handshake(tag);
    endtask

    task automatic run_u4(input logic [319:0] s, input logic sel, input string tag);
        int cyc;
        int lat;
        logic [319:0] e;
        lat = sel ? 2 : 3;
        e   = model_perm(s, sel);
        @(negedge clk);
        start_valid4 = 1'b1;
        state_in     = s;
        rounds_sel   = sel;
        @(negedge clk);
        start_valid4 = 1'b0;
        cyc = 0;
        check({tag, "_rc_first"}, {312'h0, dut4.g_lane[0].rc}, sel ? 320'hb4 : 320'hf0);
        while (!done_valid4 && cyc < 64) begin
            if (cyc == lat - 1) check({tag, "_rc_last"}, {312'h0, dut4.g_lane[3].rc}, 320'h4b);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 320'(cyc), 320'(lat));
        check({tag, "_data"}, state_out4, e);
        done_ready4 = 1'b1;
        @(negedge clk);
        done_ready4 = 1'b0;
        check({tag, "_dv_drop"}, {319'h0, done_valid4}, 320'h0);
    endtask

    typedef struct {
        logic [319:0] s;
        logic         sel;
    } vec_t;

    vec_t vt[5];
    logic [319:0] s2;

    initial begin
        rst = 1'b1;
        start_valid = 1'b0; done_ready = 1'b0; abort = 1'b0;
        start_valid4 = 1'b0; done_ready4 = 1'b0; abort4 = 1'b0;
        rounds_sel = 1'b0; state_in = '0;

        vt[0] = '{320'h0, 1'b0};
        vt[1] = '{rand320(), 1'b1};
        vt[2] = '{rand320(), 1'b0};
        vt[3] = '{{320{1'b1}}, 1'b0};
        vt[4] = '{{5{64'h0123456789abcdef}}, 1'b1};

        // reset with random inputs
        repeat (3) begin
            @(negedge clk);
            check("rst_start_ready", {319'h0, start_ready}, 320'h0);
            check("rst_done_valid", {319'h0, done_valid}, 320'h0);
            check("rst_busy", {319'h0, busy}, 320'h0);
            check("rst_state_out", state_out, 320'h0);
            start_valid = $urandom_range(0, 1);
            done_ready  = $urandom_range(0, 1);
            rounds_sel  = $urandom_range(0, 1);
            state_in    = rand320();
        end
        @(negedge clk);
        rst = 1'b0; start_valid = 1'b0; done_ready = 1'b0;
        @(negedge clk);
        check("post_rst_start_ready", {319'h0, start_ready}, 320'h1);
        check("post_rst_state_out", state_out, 320'h0);

        for (int i = 0; i < 5; i++) run_one(vt[i].s, vt[i].sel, $sformatf("vec%0d", i));

        // UNROLL = 4 instance
        run_u4(rand320(), 1'b1, "u4_p8");
        run_u4(rand320(), 1'b0, "u4_p12");

        // backpressure, then a start held through the handshake
        accept(rand320(), 1'b0, "bp");
        wait_for_done(12, 4'd0, "bp");
        repeat (5) begin
            done_ready = 1'b0;
            @(negedge clk);
            check("bp_hold_dv", {319'h0, done_valid}, 320'h1);
            check("bp_hold_data", state_out, last_exp);
        end
        s2 = rand320();
        done_ready = 1'b1; start_valid = 1'b1; state_in = s2; rounds_sel = 1'b1;
        exp_q.push_back(model_perm(s2, 1'b1));
        @(negedge clk);
        done_ready = 1'b0;
        check("bp_hs_dv", {319'h0, done_valid}, 320'h0);
        check("bp_hs_idle", {318'h0, busy, start_ready}, 320'h1);
        @(negedge clk);
        start_valid = 1'b0;
        check("bp_late_accept", {318'h0, busy, start_ready}, 320'h2);
        wait_for_done(8, 4'd4, "bp_next");
        handshake("bp_next");

        // asynchronous reset at round 6
        accept(rand320(), 1'b0, "mid_rst");
        repeat (6) @(negedge clk);
        check("mid_rst_pre_busy", {319'h0, busy}, 320'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", {319'h0, busy}, 320'h0);
        check("mid_rst_dv", {319'h0, done_valid}, 320'h0);
        check("mid_rst_state", state_out, 320'h0);
        check("mid_rst_start_ready", {319'h0, start_ready}, 320'h0);
        pop_exp("mid_rst_discard", s2);
        @(negedge clk);
        rst = 1'b0;
        run_one(rand320(), 1'b0, "after_rst");

`ifdef ASCON_PERM_ABORT_EN
        accept(rand320(), 1'b0, "abort");
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {319'h0, busy}, 320'h0);
        check("abort_state", state_out, 320'h0);
        check("abort_dv", {319'h0, done_valid}, 320'h0);
        pop_exp("abort_discard", s2);
        run_one(rand320(), 1'b0, "after_abort");
`endif

        check("scoreboard_empty", 320'(exp_q.size()), 320'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
